// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, S-box and Rcon tables, GF(2^8) xtime helper.
package aes_pkg;

    localparam int unsigned NB    = 4;
    localparam int unsigned NK    = 4;
    localparam int unsigned NR    = 10;
    localparam int unsigned NRK   = NR + 1;
    localparam int unsigned RND_W = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } cipher_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Plaintext-in / ciphertext-out valid/ready bus of the iterative AES cipher.
interface aes_cipher_iter_if;

    logic                in_valid;
    logic                in_ready;
    aes_pkg::aes_block_t plaintext;
    logic                out_valid;
    logic                out_ready;
    aes_pkg::aes_block_t ciphertext;

    modport slave (
        input  in_valid, plaintext, out_ready,
        output in_ready, out_valid, ciphertext
    );

    modport master (
        output in_valid, plaintext, out_ready,
        input  in_ready, out_valid, ciphertext
    );

endinterface

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round; MixColumns bypassed on the final round.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_block_t i_state,
    input  aes_block_t i_rk,
    input  logic       i_final_round,
    output aes_block_t o_next_c
);

    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; byte index = row + 4*column.
    always_comb begin
        w_sb     = '{default: 8'h00};
        w_sr     = '{default: 8'h00};
        w_mc     = '{default: 8'h00};
        o_next_c = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = SBOX[i_state[8*(15-i) +: 8]];
        end
        for (int c = 0; c < int'(NB); c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < int'(NB); c++) begin
            w_mc[4*c+0] = xtime(w_sr[4*c]) ^ mul3(w_sr[4*c+1]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ mul3(w_sr[4*c+2]) ^ w_sr[4*c+3];
            w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ mul3(w_sr[4*c+3]);
            w_mc[4*c+3] = mul3(w_sr[4*c]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            o_next_c[8*(15-i) +: 8] = (i_final_round ? w_sr[i] : w_mc[i]) ^ i_rk[8*(15-i) +: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor, one round per clock.
// Optional AES_CIPHER_ABORT_EN adds an abort input that discards the in-flight block.
module aes_cipher_iter
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef AES_CIPHER_ABORT_EN
    input  logic                      abort,
`endif
    input  logic [NRK-1:0][127:0]     round_keys,
    aes_cipher_iter_if.slave          bus,
    output logic                      busy
);

    cipher_state_e    r_state, w_state_nxt;
    aes_block_t       r_blk, w_blk_nxt, w_round;
    logic [RND_W-1:0] r_rnd, w_rnd_nxt;
    logic             r_in_ready, r_out_valid, r_busy;
    logic             w_final, w_abort;

    assign w_final = (r_rnd == RND_W'(NR));

`ifdef AES_CIPHER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_round_comb u_round (
        .i_state      (r_blk),
        .i_rk         (round_keys[r_rnd]),
        .i_final_round(w_final),
        .o_next_c     (w_round)
    );

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = r_blk;
        w_rnd_nxt   = r_rnd;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_blk_nxt   = bus.plaintext ^ round_keys[0];
                    w_rnd_nxt   = RND_W'(1);
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_blk_nxt = w_round;
                if (w_final) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_rnd_nxt = r_rnd + RND_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_rnd_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rnd_nxt   = '0;
            end
        endcase
        if (w_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_blk_nxt   = '0;
            w_rnd_nxt   = '0;
        end
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_blk       <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk       <= w_blk_nxt;
            r_rnd       <= w_rnd_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.ciphertext = r_blk;
    assign busy           = r_busy;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter using FIPS-197 vectors and handshake corner cases.
module tb_aes_cipher_iter;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [10:0][127:0] rk;
    logic              busy;
`ifdef AES_CIPHER_ABORT_EN
    logic              abort;
`endif

    aes_cipher_iter_if bus ();

    aes_cipher_iter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES_CIPHER_ABORT_EN
        .abort     (abort),
`endif
        .round_keys(rk),
        .bus       (bus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_pass = 0;
    int         n_tot  = 0;
    int         lat;
    int         acc [4];
    logic       seen;
    logic [7:0] tb_sbox [256];
    vec_t       vecs [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from the GF(2^8) inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [10:0][127:0] expand(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [10:0][127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    // Called at a negedge with the DUT idle; runs one block with out_ready high.
    task automatic run_vec(input int k);
        int l;
        chk($sformatf("v%0d_rdy_pre", k), bus.in_ready, 1'b1);
        rk            = expand(vecs[k].key);
        bus.plaintext = vecs[k].pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk($sformatf("v%0d_busy", k), busy, 1'b1);
        chk($sformatf("v%0d_rdy_busy", k), bus.in_ready, 1'b0);
        l = 0;
        while (!bus.out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
        chk($sformatf("v%0d_latency", k), l, 10);
        chk($sformatf("v%0d_ct", k), bus.ciphertext, vecs[k].ct);
        @(negedge clk);
        chk($sformatf("v%0d_ov_post", k), bus.out_valid, 1'b0);
        chk($sformatf("v%0d_rdy_post", k), bus.in_ready, 1'b1);
        chk($sformatf("v%0d_busy_post", k), busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h0, pt: 128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = vecs[0];

        rst_n         = 1'b1;
        rk            = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
`ifdef AES_CIPHER_ABORT_EN
        abort = 1'b0;
`endif
        build_sbox();
        #1 rst_n = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ct", bus.ciphertext, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) run_vec(k);

        // Backpressure: DONE held for 20 cycles while in_valid pulses are ignored.
        rk            = expand(vecs[1].key);
        bus.plaintext = vecs[1].pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 10);
        bus.plaintext = vecs[0].pt;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("bp_ct_%0d", i), bus.ciphertext, vecs[1].ct);
            chk($sformatf("bp_ov_%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("bp_rdy_%0d", i), bus.in_ready, 1'b0);
            bus.in_valid = i[0];
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_ov_release", bus.out_valid, 1'b0);
        chk("bp_rdy_release", bus.in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("bp_no_latch", busy, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b%0d_rdy", k), bus.in_ready, 1'b1);
            rk            = expand(vecs[k].key);
            bus.plaintext = vecs[k].pt;
            acc[k]        = cyc;
            if (k > 0) chk($sformatf("b2b%0d_spacing", k), acc[k] - acc[k-1], 12);
            @(posedge clk);
            @(negedge clk);
            lat = 0;
            while (!bus.out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("b2b%0d_latency", k), lat, 10);
            chk($sformatf("b2b%0d_ct", k), bus.ciphertext, vecs[k].ct);
            @(negedge clk);
            if (k == 3) bus.in_valid = 1'b0;
        end

        // Asynchronous reset in the middle of a block.
        rk            = expand(vecs[0].key);
        bus.plaintext = vecs[0].pt;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", bus.in_ready, 1'b1);
        chk("mrst_out_valid", bus.out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ct", bus.ciphertext, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mrst_no_out_valid", seen, 1'b0);
        run_vec(0);

`ifdef AES_CIPHER_ABORT_EN
        // Abort during round 3 discards the block.
        rk            = expand(vecs[0].key);
        bus.plaintext = vecs[0].pt;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_ct", bus.ciphertext, 128'h0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 1'b0);
        run_vec(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
